// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage and 32-entry architectural register file.
// Picks the writeback value from the MEM/WB fields and commits it at the clock
// edge. Two combinational ID read ports see the array, plus an optional
// same-cycle write-through so ID never needs a separate WB->ID forward.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,              // synchronous, active-low
    input  logic              RegWrite_in,
    input  logic [1:0]        MemToReg_in,
    input  logic [DATA_W-1:0] ReadDataMem_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [ADDR_W-1:0] RegDestination_in,
    input  logic [DATA_W-1:0] PCPlus8_in,
    input  logic [ADDR_W-1:0] ReadReg1_in,
    input  logic [ADDR_W-1:0] ReadReg2_in,
    output logic [DATA_W-1:0] ReadData1_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] WriteData_out,
    output logic              WriteValid_out,
    output logic [31:0]       WriteCount_out
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [31:0]       write_count;

    // Writeback select; code 11 is reserved and falls back to the ALU result.
    always_comb begin
        WriteData_out = ALUResult_in;
        case (MemToReg_in)
            2'b01:   WriteData_out = ReadDataMem_in;
            2'b10:   WriteData_out = PCPlus8_in;
            default: WriteData_out = ALUResult_in;
        endcase
    end

    // $0 is hardwired, so a write aimed at it is not a commit at all.
    assign WriteValid_out = reset & RegWrite_in & (RegDestination_in != '0);
    assign WriteCount_out = write_count;

    // Read port 1: reset and $0 force zero, then bypass, then the array.
    always_comb begin
        ReadData1_out = regs[ReadReg1_in];
        if (!reset || ReadReg1_in == '0)
            ReadData1_out = '0;
        else if (BYPASS && WriteValid_out && ReadReg1_in == RegDestination_in)
            ReadData1_out = WriteData_out;
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        ReadData2_out = regs[ReadReg2_in];
        if (!reset || ReadReg2_in == '0)
            ReadData2_out = '0;
        else if (BYPASS && WriteValid_out && ReadReg2_in == RegDestination_in)
            ReadData2_out = WriteData_out;
    end

    // Commit and commit counter; reset clears everything and drops any write
    // presented in the same cycle (WriteValid_out is already 0 then).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            write_count <= '0;
        end else begin
            if (WriteValid_out)
                regs[RegDestination_in] <= WriteData_out;
            write_count <= write_count + {31'd0, WriteValid_out};
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios then random traffic against a
// behavioural register-file model held in plain arrays.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in;
    logic [1:0]  MemToReg_in;
    logic [31:0] ReadDataMem_in, ALUResult_in, PCPlus8_in;
    logic [4:0]  RegDestination_in, ReadReg1_in, ReadReg2_in;
    logic [31:0] ReadData1_out, ReadData2_out, WriteData_out, WriteCount_out;
    logic        WriteValid_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .ReadDataMem_in(ReadDataMem_in), .ALUResult_in(ALUResult_in),
        .RegDestination_in(RegDestination_in), .PCPlus8_in(PCPlus8_in),
        .ReadReg1_in(ReadReg1_in), .ReadReg2_in(ReadReg2_in),
        .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
        .WriteData_out(WriteData_out), .WriteValid_out(WriteValid_out),
        .WriteCount_out(WriteCount_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_wdata();
        if (MemToReg_in == 2'd1) return ReadDataMem_in;
        if (MemToReg_in == 2'd2) return PCPlus8_in;
        return ALUResult_in;
    endfunction

    function automatic logic m_valid();
        return reset && RegWrite_in && RegDestination_in != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (!reset || idx == 5'd0) return 32'd0;
        if (m_valid() && idx == RegDestination_in) return m_wdata();
        return m_regs[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wd"},  WriteData_out, m_wdata());
        chk({tag, "_wv"},  {31'd0, WriteValid_out}, {31'd0, m_valid()});
        chk({tag, "_rd1"}, ReadData1_out, m_read(ReadReg1_in));
        chk({tag, "_rd2"}, ReadData2_out, m_read(ReadReg2_in));
        chk({tag, "_cnt"}, WriteCount_out, m_count);
    endtask

    // Check at negedge, advance the model at the posedge, release inputs at +1.
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_count = 32'd0;
        end else if (m_valid()) begin
            m_regs[RegDestination_in] = m_wdata();
            m_count = m_count + 32'd1;
        end
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] mtr, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [4:0] r1, input logic [4:0] r2);
        RegWrite_in = rw; MemToReg_in = mtr; RegDestination_in = dest;
        ALUResult_in = alu; ReadReg1_in = r1; ReadReg2_in = r2;
    endtask

    initial begin
        logic [31:0] exp_r8 [3];
        exp_r8[0] = 32'h11; exp_r8[1] = 32'h22; exp_r8[2] = 32'h33;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
        m_count = 32'hx;
        reset = 1'b0;
        ReadDataMem_in = 32'h22; PCPlus8_in = 32'h33;
        drive(1'b0, 2'd0, 5'd0, 32'h11, 5'd0, 5'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
        step("rst0");
        reset = 1'b1;

        // Reset wipes a written register.
        drive(1'b1, 2'd0, 5'd5, 32'hAA, 5'd5, 5'd5);
        step("w5");
        reset = 1'b0; RegWrite_in = 1'b0;
        step("rst1a"); step("rst1b");
        reset = 1'b1; #1;
        chk("t1_r5", ReadData1_out, 32'd0);
        chk("t1_cnt", WriteCount_out, 32'd0);

        // Writeback mux selects, each visible from the array next cycle.
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'(s), 5'd8, 32'h11, 5'd1, 5'd2);
            step("mux");
            drive(1'b0, 2'd0, 5'd8, 32'h11, 5'd8, 5'd3);
            #1 chk("t2_r8", ReadData1_out, exp_r8[s]);
            step("mux_rd");
        end
        chk("t2_cnt3", WriteCount_out, 32'd3);
        drive(1'b1, 2'd3, 5'd8, 32'h11, 5'd1, 5'd2);
        ReadDataMem_in = 32'h99; PCPlus8_in = 32'h77;
        step("mux3");
        drive(1'b0, 2'd0, 5'd0, 32'h0, 5'd8, 5'd8);
        #1 chk("t2_r8_res", ReadData2_out, 32'h11);
        step("mux3_rd");

        // $0 guard.
        drive(1'b1, 2'd0, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        #1 chk("t3_rd1_pre", ReadData1_out, 32'd0);
        chk("t3_rd2_pre", ReadData2_out, 32'd0);
        chk("t3_wv", {31'd0, WriteValid_out}, 32'd0);
        step("z");
        RegWrite_in = 1'b0;
        #1 chk("t3_rd1_post", ReadData1_out, 32'd0);
        chk("t3_cnt", WriteCount_out, 32'd4);

        // Same-cycle write-through on both ports.
        drive(1'b1, 2'd0, 5'd9, 32'h1, 5'd0, 5'd0);
        step("w9");
        drive(1'b1, 2'd0, 5'd9, 32'hABCD, 5'd9, 5'd9);
        #1 chk("t4_rd1", ReadData1_out, 32'hABCD);
        chk("t4_rd2", ReadData2_out, 32'hABCD);
        step("byp");

        // Reset colliding with a write.
        drive(1'b1, 2'd0, 5'd4, 32'h55, 5'd4, 5'd4);
        reset = 1'b0;
        step("rcol");
        reset = 1'b1; RegWrite_in = 1'b0;
        #1 chk("t5_r4", ReadData1_out, 32'd0);
        chk("t5_cnt", WriteCount_out, 32'd0);

        // Counter wrap.
        force dut.write_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.write_count;
        m_count = 32'hFFFF_FFFF;
        chk("t6_pre", WriteCount_out, 32'hFFFF_FFFF);
        drive(1'b1, 2'd0, 5'd7, 32'h7, 5'd7, 5'd1);
        step("wrap");
        RegWrite_in = 1'b0;
        #1 chk("t6_wrap", WriteCount_out, 32'd0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 24) != 0);
            RegWrite_in = $urandom_range(0, 3) != 0;
            MemToReg_in = 2'($urandom_range(0, 3));
            ALUResult_in = $urandom; ReadDataMem_in = $urandom; PCPlus8_in = $urandom;
            RegDestination_in = 5'($urandom_range(0, 31));
            ReadReg1_in = ($urandom_range(0, 3) == 0) ? RegDestination_in : 5'($urandom_range(0, 31));
            ReadReg2_in = ($urandom_range(0, 3) == 0) ? RegDestination_in : 5'($urandom_range(0, 31));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
